// File: rtl/demultiplexer_1_to_2_case.sv
// Registered 1-to-2 demultiplexer with optional per-output 1-bit counters.
// Counters are built only when DEMUX_STATS_EN is defined; otherwise tied to 0.
module demultiplexer_1_to_2_case #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         A,
    output logic [1:0]         W,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
);

    logic [1:0] w_route;
    logic [1:0] r_w;

    // A[1] selects the line, A[0] is the data; X/Z lands in default
    always_comb begin
        w_route = 2'b00;
        case (A)
            2'b00:   w_route = 2'b00;
            2'b01:   w_route = 2'b01;
            2'b10:   w_route = 2'b00;
            2'b11:   w_route = 2'b10;
            default: w_route = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w <= 2'b00;
        end else begin
            r_w <= w_route;
        end
    end

    assign W = r_w;

`ifdef DEMUX_STATS_EN
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [COUNT_W-1:0] r_cnt0;
    logic [COUNT_W-1:0] r_cnt1;

    // Saturating counters advance on the same edge that loads the W bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_route[0] && (r_cnt0 != CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + COUNT_W'(1);
            end
            if (w_route[1] && (r_cnt1 != CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + COUNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demultiplexer_1_to_2_case.sv
// Randomised and directed bench for demultiplexer_1_to_2_case.
// Runs a default-width DUT and a 3-bit-counter DUT side by side.
module tb_demultiplexer_1_to_2_case;

`ifdef DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  A;
    logic [1:0]  W;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  W_s;
    logic [2:0]  cnt0_s;
    logic [2:0]  cnt1_s;

    int n_checks;
    int n_errors;

    // reference state: expected W and raw 1-bit tallies since reset
    logic [1:0] m_w;
    int         m_n0;
    int         m_n1;

    demultiplexer_1_to_2_case #(.COUNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .W     (W),
        .cnt0  (cnt0),
        .cnt1  (cnt1)
    );

    demultiplexer_1_to_2_case #(.COUNT_W(3)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .W     (W_s),
        .cnt0  (cnt0_s),
        .cnt1  (cnt1_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_exp(input int n, input int width);
        int mx;
        mx = (1 << width) - 1;
        if (!STATS) return 0;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".W"},       32'(W),      32'(m_w));
        chk({tag, ".cnt0"},    32'(cnt0),   32'(sat_exp(m_n0, 16)));
        chk({tag, ".cnt1"},    32'(cnt1),   32'(sat_exp(m_n1, 16)));
        chk({tag, ".W_s"},     32'(W_s),    32'(m_w));
        chk({tag, ".cnt0_s"},  32'(cnt0_s), 32'(sat_exp(m_n0, 3)));
        chk({tag, ".cnt1_s"},  32'(cnt1_s), 32'(sat_exp(m_n1, 3)));
    endtask

    // one clock: drive at negedge, update model, check after the edge,
    // then wiggle A mid-cycle and confirm outputs do not move
    task automatic step(input logic [1:0] a, input logic r, input string tag);
        @(negedge clk);
        A     = a;
        rst_n = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m_w  = 2'b00;
            m_n0 = 0;
            m_n1 = 0;
        end else begin
            m_w  = a[0] ? (2'b01 << a[1]) : 2'b00;
            m_n0 = m_n0 + ((a == 2'b01) ? 1 : 0);
            m_n1 = m_n1 + ((a == 2'b11) ? 1 : 0);
        end
        check_all(tag);
        A = ~a;
        #1;
        chk({tag, ".hold"}, 32'(W), 32'(m_w));
    endtask

    logic [15:0] din;

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_w      = 2'b00;
        m_n0     = 0;
        m_n1     = 0;
        A        = 2'b11;
        rst_n    = 1'b0;

        step(2'b11, 1'b0, "rst0");
        step(2'b11, 1'b0, "rst1");

        step(2'b00, 1'b1, "tt00");
        step(2'b01, 1'b1, "tt01");
        step(2'b10, 1'b1, "tt10");
        step(2'b11, 1'b1, "tt11");

        step(2'b00, 1'b0, "prestream_rst");
        din = 16'b1111100110011011;
        for (int i = 0; i < 16; i++) begin
            step({1'b0, din[i]}, 1'b1, "stream_d");
            chk("stream_w0", 32'(W[0]), 32'(din[i]));
            step(2'b11, 1'b1, "stream_i");
            chk("stream_w10", 32'(W), 32'(2'b10));
        end
        chk("stream_cnt0", 32'(cnt0), STATS ? 32'd11 : 32'd0);
        chk("stream_cnt1", 32'(cnt1), STATS ? 32'd16 : 32'd0);

        step(2'b11, 1'b0, "mid_rst");
        chk("mid_rst_w", 32'(W), 32'd0);
        step(2'b11, 1'b1, "mid_resume");

        step(2'b00, 1'b0, "presat_rst");
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 1'b1, "sat");
        end
        chk("sat_cnt0_s", 32'(cnt0_s), STATS ? 32'd7 : 32'd0);
        chk("sat_cnt1_s", 32'(cnt1_s), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(2'($urandom), ($urandom_range(0, 19) != 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
